// File: rtl/stopwatch_lap_ctrl_pkg.sv
// Shared state codes, button indices and field limits for the stopwatch controller.
// The state encoding doubles as the LED code driven to the board.
package stopwatch_lap_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'b000,
      S_WAIT = 3'b001,
      S_CNT  = 3'b010,
      S_LAP  = 3'b011,
      S_STOP = 3'b100
   } state_t;

   localparam int BTN_ARM = 0;
   localparam int BTN_RUN = 1;
   localparam int BTN_CLR = 2;

   localparam int SEC_MAX = 59;

   function automatic logic isRunning(input state_t s);
      return (s == S_CNT) || (s == S_LAP);
   endfunction

endpackage

// File: rtl/stopwatch_lap_ctrl_btn_debounce.sv
// One button: 2-FF synchroniser, stability counter, accepted level and a one-cycle press pulse.
module btn_debounce #(
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic clk100Mhz,
   input  logic rst_n,
   input  logic raw,
   output logic press
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic syncA;
   logic syncB;
   logic level;
   logic [CW-1:0] stableCnt;

   // A new level is accepted only after DB_CYCLES consecutive differing samples; only 0->1 pulses.
   always_ff @(posedge clk100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         syncA     <= 1'b0;
         syncB     <= 1'b0;
         level     <= 1'b0;
         stableCnt <= '0;
         press     <= 1'b0;
      end else begin
         syncA <= raw;
         syncB <= syncA;
         press <= 1'b0;
         if (syncB == level) begin
            stableCnt <= '0;
         end else if (stableCnt == CNT_LAST) begin
            level     <= syncB;
            stableCnt <= '0;
            press     <= syncB;
         end else begin
            stableCnt <= stableCnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller: debounced buttons, IDLE/WAIT/CNT/STOP/LAP FSM and MM:SS.cc counter.
// Define STOPWATCH_LAP_EN to build the LAP state and its display-freeze capture registers.
module stopwatch_lap_ctrl
   import stopwatch_lap_ctrl_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int TICK_HZ   = 100,
   parameter int DB_CYCLES = 1_000_000,
   parameter int CS_MAX    = 99,
   parameter int MIN_MAX   = 59
) (
   input  logic       clk100Mhz,
   input  logic       rst_n,
   input  logic [2:0] btnRaw,
   output logic [5:0] min,
   output logic [5:0] sec,
   output logic [6:0] csec,
   output logic [2:0] led,
   output logic       running,
   output logic       ovf
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_t state;
   state_t nextState;
   logic [2:0] press;
   logic [PW-1:0] presc;
   logic [5:0] minCnt, minNext;
   logic [5:0] secCnt, secNext;
   logic [6:0] csecCnt, csecNext;
   logic tick;
   logic wrap;
   logic counting;
   logic enterWait;

   for (genvar i = 0; i < 3; i++) begin : g_db
      btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clk100Mhz(clk100Mhz),
         .rst_n    (rst_n),
         .raw      (btnRaw[i]),
         .press    (press[i])
      );
   end

   always_ff @(posedge clk100Mhz or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nextState;
   end

   // Only the highest-priority pulse (run > clear > arm) is considered; the others are dropped.
   always_comb begin
      nextState = state;
      if (press[BTN_RUN]) begin
         case (state)
            S_WAIT, S_STOP: nextState = S_CNT;
            S_CNT:          nextState = S_STOP;
`ifdef STOPWATCH_LAP_EN
            S_LAP:          nextState = S_STOP;
`endif
            default:        nextState = state;
         endcase
      end else if (press[BTN_CLR]) begin
         case (state)
`ifdef STOPWATCH_LAP_EN
            S_CNT:          nextState = S_LAP;
            S_LAP:          nextState = S_CNT;
`endif
            S_STOP:         nextState = S_WAIT;
            default:        nextState = state;
         endcase
      end else if (press[BTN_ARM] && state == S_IDLE) begin
         nextState = S_WAIT;
      end
   end

   assign counting  = isRunning(state);
   assign enterWait = (nextState == S_WAIT) && (state != S_WAIT);

   // Incremented time for this cycle; shared by the counter registers and the lap capture.
   always_comb begin
      tick     = counting && (presc == PW'(TICK_DIV - 1));
      wrap     = 1'b0;
      csecNext = csecCnt;
      secNext  = secCnt;
      minNext  = minCnt;
      if (tick) begin
         if (csecCnt == 7'(CS_MAX)) begin
            csecNext = '0;
            if (secCnt == 6'(SEC_MAX)) begin
               secNext = '0;
               if (minCnt == 6'(MIN_MAX)) begin
                  minNext = '0;
                  wrap    = 1'b1;
               end else begin
                  minNext = minCnt + 6'd1;
               end
            end else begin
               secNext = secCnt + 6'd1;
            end
         end else begin
            csecNext = csecCnt + 7'd1;
         end
      end
   end

   always_ff @(posedge clk100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         presc   <= '0;
         csecCnt <= '0;
         secCnt  <= '0;
         minCnt  <= '0;
         ovf     <= 1'b0;
      end else if (enterWait) begin
         presc   <= '0;
         csecCnt <= '0;
         secCnt  <= '0;
         minCnt  <= '0;
         ovf     <= 1'b0;
      end else if (counting) begin
         presc   <= tick ? '0 : presc + 1'b1;
         csecCnt <= csecNext;
         secCnt  <= secNext;
         minCnt  <= minNext;
         if (wrap) ovf <= 1'b1;
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic [5:0] lapMin;
   logic [5:0] lapSec;
   logic [6:0] lapCsec;

   // Capture includes any tick landing on the CNT->LAP edge so the frozen value matches live time.
   always_ff @(posedge clk100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         lapMin  <= '0;
         lapSec  <= '0;
         lapCsec <= '0;
      end else if (state == S_CNT && nextState == S_LAP) begin
         lapMin  <= minNext;
         lapSec  <= secNext;
         lapCsec <= csecNext;
      end
   end

   assign min  = (state == S_LAP) ? lapMin  : minCnt;
   assign sec  = (state == S_LAP) ? lapSec  : secCnt;
   assign csec = (state == S_LAP) ? lapCsec : csecCnt;
`else
   assign min  = minCnt;
   assign sec  = secCnt;
   assign csec = csecCnt;
`endif

   assign led     = state;
   assign running = counting;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl with TICK_DIV=10, DB_CYCLES=4, MIN_MAX=0.
// A press takes 7 rising edges from raw assertion to the state change; tasks start and end at a falling edge.
module tb_stopwatch_lap_ctrl;

   logic       clk100Mhz = 1'b0;
   logic       rst_n;
   logic [2:0] btnRaw;
   logic [5:0] min;
   logic [5:0] sec;
   logic [6:0] csec;
   logic [2:0] led;
   logic       running;
   logic       ovf;

   int passed = 0;
   int total  = 0;

   stopwatch_lap_ctrl #(
      .CLK_HZ   (1000),
      .TICK_HZ  (100),
      .DB_CYCLES(4),
      .CS_MAX   (99),
      .MIN_MAX  (0)
   ) dut (
      .clk100Mhz(clk100Mhz),
      .rst_n    (rst_n),
      .btnRaw   (btnRaw),
      .min      (min),
      .sec      (sec),
      .csec     (csec),
      .led      (led),
      .running  (running),
      .ovf      (ovf)
   );

   always #5 clk100Mhz = ~clk100Mhz;

   task automatic cycles(input int n);
      repeat (n) @(posedge clk100Mhz);
      @(negedge clk100Mhz);
   endtask

   task automatic pressBtn(input logic [2:0] mask);
      btnRaw = btnRaw | mask;
      cycles(7);
   endtask

   task automatic releaseBtn(input logic [2:0] mask);
      btnRaw = btnRaw & ~mask;
      cycles(7);
   endtask

   task automatic test_reset;
      total++; if (led !== 3'b000) $display("[TB] FAIL reset_led: got %b expected 000", led); else passed++;
      total++; if (min !== 6'd0) $display("[TB] FAIL reset_min: got %0d expected 0", min); else passed++;
      total++; if (sec !== 6'd0) $display("[TB] FAIL reset_sec: got %0d expected 0", sec); else passed++;
      total++; if (csec !== 7'd0) $display("[TB] FAIL reset_csec: got %0d expected 0", csec); else passed++;
      total++; if (running !== 1'b0) $display("[TB] FAIL reset_running: got %b expected 0", running); else passed++;
      total++; if (ovf !== 1'b0) $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); else passed++;
   endtask

   task automatic test_bounce;
      for (int i = 0; i < 10; i++) begin
         btnRaw[0] = ~btnRaw[0];
         cycles(2);
      end
      total++; if (led !== 3'b000) $display("[TB] FAIL bounce_ignored: got %b expected 000", led); else passed++;
      btnRaw[0] = 1'b1;
      cycles(10);
      total++; if (led !== 3'b001) $display("[TB] FAIL bounce_wait: got %b expected 001", led); else passed++;
      releaseBtn(3'b001);
      total++; if (led !== 3'b001) $display("[TB] FAIL bounce_release: got %b expected 001", led); else passed++;
   endtask

   task automatic test_start_stop;
      pressBtn(3'b010);
      total++; if (led !== 3'b010) $display("[TB] FAIL start_led: got %b expected 010", led); else passed++;
      total++; if (running !== 1'b1) $display("[TB] FAIL start_running: got %b expected 1", running); else passed++;
      releaseBtn(3'b010);
      cycles(243);
      total++; if (csec !== 7'd25) $display("[TB] FAIL run_250: got %0d expected 25", csec); else passed++;
      pressBtn(3'b010);
      total++; if (led !== 3'b100) $display("[TB] FAIL stop_led: got %b expected 100", led); else passed++;
      total++; if (csec !== 7'd25) $display("[TB] FAIL stop_csec: got %0d expected 25", csec); else passed++;
      releaseBtn(3'b010);
      cycles(100);
      total++; if (csec !== 7'd25) $display("[TB] FAIL stop_hold: got %0d expected 25", csec); else passed++;
      total++; if (running !== 1'b0) $display("[TB] FAIL stop_running: got %b expected 0", running); else passed++;
   endtask

   task automatic test_resume_clear;
      pressBtn(3'b010);
      total++; if (led !== 3'b010) $display("[TB] FAIL resume_led: got %b expected 010", led); else passed++;
      cycles(2);
      total++; if (csec !== 7'd25) $display("[TB] FAIL resume_pre_tick: got %0d expected 25", csec); else passed++;
      cycles(1);
      total++; if (csec !== 7'd26) $display("[TB] FAIL resume_tick: got %0d expected 26", csec); else passed++;
      releaseBtn(3'b010);
      pressBtn(3'b010);
      total++; if (csec !== 7'd27) $display("[TB] FAIL restop_csec: got %0d expected 27", csec); else passed++;
      releaseBtn(3'b010);
      pressBtn(3'b100);
      total++; if (led !== 3'b001) $display("[TB] FAIL clear_led: got %b expected 001", led); else passed++;
      total++; if (csec !== 7'd0) $display("[TB] FAIL clear_csec: got %0d expected 0", csec); else passed++;
      total++; if (ovf !== 1'b0) $display("[TB] FAIL clear_ovf: got %b expected 0", ovf); else passed++;
      releaseBtn(3'b100);
   endtask

   task automatic test_lap;
      pressBtn(3'b010);
      releaseBtn(3'b010);
      cycles(90);
      pressBtn(3'b100);
`ifdef STOPWATCH_LAP_EN
      total++; if (led !== 3'b011) $display("[TB] FAIL lap_led: got %b expected 011", led); else passed++;
      total++; if (running !== 1'b1) $display("[TB] FAIL lap_running: got %b expected 1", running); else passed++;
      total++; if (csec !== 7'd10) $display("[TB] FAIL lap_capture: got %0d expected 10", csec); else passed++;
      cycles(50);
      total++; if (csec !== 7'd10) $display("[TB] FAIL lap_frozen: got %0d expected 10", csec); else passed++;
      releaseBtn(3'b100);
      cycles(136);
      pressBtn(3'b100);
      total++; if (led !== 3'b010) $display("[TB] FAIL lap_exit_led: got %b expected 010", led); else passed++;
      total++; if (csec !== 7'd30) $display("[TB] FAIL lap_exit_live: got %0d expected 30", csec); else passed++;
`else
      total++; if (led !== 3'b010) $display("[TB] FAIL nolap_led: got %b expected 010", led); else passed++;
      total++; if (running !== 1'b1) $display("[TB] FAIL nolap_running: got %b expected 1", running); else passed++;
      total++; if (csec !== 7'd10) $display("[TB] FAIL nolap_live: got %0d expected 10", csec); else passed++;
      cycles(50);
      total++; if (csec !== 7'd15) $display("[TB] FAIL nolap_counting: got %0d expected 15", csec); else passed++;
      releaseBtn(3'b100);
      cycles(136);
      pressBtn(3'b100);
      total++; if (led !== 3'b010) $display("[TB] FAIL nolap_b2_led: got %b expected 010", led); else passed++;
      total++; if (csec !== 7'd30) $display("[TB] FAIL nolap_b2_csec: got %0d expected 30", csec); else passed++;
`endif
      releaseBtn(3'b100);
      pressBtn(3'b010);
      releaseBtn(3'b010);
      pressBtn(3'b100);
      releaseBtn(3'b100);
      total++; if (led !== 3'b001) $display("[TB] FAIL lap_back_wait: got %b expected 001", led); else passed++;
   endtask

   task automatic test_wrap;
      pressBtn(3'b010);
      releaseBtn(3'b010);
      cycles(59992);
      total++; if (sec !== 6'd59) $display("[TB] FAIL wrap_pre_sec: got %0d expected 59", sec); else passed++;
      total++; if (csec !== 7'd99) $display("[TB] FAIL wrap_pre_csec: got %0d expected 99", csec); else passed++;
      total++; if (ovf !== 1'b0) $display("[TB] FAIL wrap_pre_ovf: got %b expected 0", ovf); else passed++;
      cycles(1);
      total++; if ({min, sec, csec} !== 19'd0) $display("[TB] FAIL wrap_zero: got %0d:%0d.%0d expected 0:0.0", min, sec, csec); else passed++;
      total++; if (ovf !== 1'b1) $display("[TB] FAIL wrap_ovf: got %b expected 1", ovf); else passed++;
      cycles(10);
      total++; if (csec !== 7'd1) $display("[TB] FAIL wrap_counting: got %0d expected 1", csec); else passed++;
      pressBtn(3'b110);
      total++; if (led !== 3'b100) $display("[TB] FAIL dual_press_led: got %b expected 100", led); else passed++;
      total++; if (csec !== 7'd1) $display("[TB] FAIL dual_press_csec: got %0d expected 1", csec); else passed++;
      total++; if (ovf !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b expected 1", ovf); else passed++;
      releaseBtn(3'b110);
   endtask

   task automatic test_async_reset;
      pressBtn(3'b010);
      releaseBtn(3'b010);
      cycles(20);
      #2 rst_n = 1'b0;
      #1;
      total++; if (led !== 3'b000) $display("[TB] FAIL areset_led: got %b expected 000", led); else passed++;
      total++; if ({min, sec, csec} !== 19'd0) $display("[TB] FAIL areset_time: got %0d:%0d.%0d expected 0:0.0", min, sec, csec); else passed++;
      total++; if (running !== 1'b0) $display("[TB] FAIL areset_running: got %b expected 0", running); else passed++;
      total++; if (ovf !== 1'b0) $display("[TB] FAIL areset_ovf: got %b expected 0", ovf); else passed++;
      @(negedge clk100Mhz);
      rst_n = 1'b1;
      pressBtn(3'b010);
      total++; if (led !== 3'b000) $display("[TB] FAIL idle_ignores_b1: got %b expected 000", led); else passed++;
      releaseBtn(3'b010);
      pressBtn(3'b001);
      total++; if (led !== 3'b001) $display("[TB] FAIL idle_after_reset: got %b expected 001", led); else passed++;
      releaseBtn(3'b001);
   endtask

   initial begin
      rst_n  = 1'b0;
      btnRaw = 3'b000;
      cycles(3);
      test_reset();
      rst_n = 1'b1;
      cycles(2);
      test_bounce();
      test_start_stop();
      test_resume_clear();
      test_lap();
      test_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
